// File: rtl/ysyx_25030093_pkg.sv
// Shared constants and the queue entry type for the fetch queue.
// The queue may be built with the YSYX_25030093_FQ_BYPASS_EN macro; see the top-level file.
package ysyx_25030093_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/ysyx_25030093_sync_fifo.sv
// Power-of-two synchronous FIFO with flush and occupancy count.
// Reset is synchronous and active-low; flush wins over push and pop.
module ysyx_25030093_sync_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 64,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full, push_ok, pop_ok;

  always_comb begin
    full    = (count_q == CntW'(Depth));
    empty_o = (count_q == '0);
    push_ok = push_i & ~full;
    pop_ok  = pop_i & ~empty_o;
    rdata_o = mem_q[rd_ptr_q];
    count_o = count_q;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + AddrW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AddrW'(1);
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + CntW'(1);
      end else if (!push_ok && pop_ok) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ysyx_25030093_fetch_queue.sv
// Instruction fetch queue: credit-based request issue, in-order responses, redirect flush.
// Define YSYX_25030093_FQ_BYPASS_EN to present a response in its arrival cycle when the queue is empty.
module ysyx_25030093_fetch_queue #(
  parameter int unsigned     XLEN     = ysyx_25030093_pkg::XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = ysyx_25030093_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  typedef ysyx_25030093_pkg::fq_entry_t entry_t;

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW:0] UseLimit = (CntW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CntW-1:0] inflight_q, inflight_d, drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0] fifo_count;
  logic [CntW:0]   in_use;
  logic [XLEN-1:0] redirect_base;
  logic            fifo_empty, fifo_push, fifo_pop;
  logic            req_fire, resp_stale, resp_take, bypass;
  entry_t          wr_entry, rd_entry;

  // Request side: credits cover both queued entries and responses still in flight.
  always_comb begin
    redirect_base = redirect_pc & ~XLEN'(3);
    in_use        = {1'b0, fifo_count} + {1'b0, inflight_q};
    req_valid     = rst & ~redirect_valid & (in_use < UseLimit);
    req_addr      = fetch_pc_q;
    req_fire      = req_valid & req_ready;
    resp_stale    = redirect_valid | (drop_cnt_q != '0);
    resp_take     = rst & resp_valid & ~resp_stale;
  end

  always_comb begin
    inflight_d = inflight_q;
    if (req_fire && !resp_valid) begin
      inflight_d = inflight_q + CntW'(1);
    end else if (!req_fire && resp_valid && (inflight_q != '0)) begin
      inflight_d = inflight_q - CntW'(1);
    end

    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      // This cycle's response is already excluded through inflight_d.
      drop_cnt_d = inflight_d;
    end else if (resp_valid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CntW'(1);
    end

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_base;
      resp_pc_d  = redirect_base;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (resp_take) begin
        resp_pc_d = resp_pc_q + XLEN'(4);
      end
    end
  end

`ifdef YSYX_25030093_FQ_BYPASS_EN
  assign bypass = fifo_empty & resp_take;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    wr_entry.pc   = resp_pc_q;
    wr_entry.inst = resp_data;
    out_valid     = ~fifo_empty | bypass;
    out_pc        = bypass ? resp_pc_q : rd_entry.pc;
    out_inst      = bypass ? resp_data : rd_entry.inst;
    // A bypassed entry consumed this cycle never needs a slot.
    fifo_push     = resp_take & ~(bypass & out_ready);
    fifo_pop      = ~fifo_empty & out_ready;
  end

  ysyx_25030093_sync_fifo #(
    .Depth (DEPTH),
    .Width ($bits(entry_t))
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (redirect_valid),
    .push_i  (fifo_push),
    .wdata_i (wr_entry),
    .pop_i   (fifo_pop),
    .rdata_o (rd_entry),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_fetch_queue.sv
// Directed bench for the fetch queue with an in-order fixed-latency memory model.
// Bypass expectations follow YSYX_25030093_FQ_BYPASS_EN, matching the RTL build.
module tb_ysyx_25030093_fetch_queue;

  localparam int unsigned Depth = 4;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  logic        req_fired, out_fired;
  logic [31:0] req_fired_addr, out_fired_pc, out_fired_inst;

  ysyx_25030093_fetch_queue #(
    .XLEN     (32),
    .DEPTH    (Depth),
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  // One clock: record handshakes, advance, then drive the memory response for the new cycle.
  task automatic tick();
    #1;
    req_fired      = rst && req_valid && req_ready;
    req_fired_addr = req_addr;
    out_fired      = out_valid && out_ready;
    out_fired_pc   = out_pc;
    out_fired_inst = out_inst;
    if (req_fired) begin
      pend_addr.push_back(req_addr);
      pend_due.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cyc++;
    resp_valid = 1'b0;
    resp_data  = '0;
    if (!rst) begin
      pend_addr.delete();
      pend_due.delete();
    end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      resp_valid = 1'b1;
      resp_data  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_ready = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_ready = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_valid: got %b want 0", req_valid);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL release_req: got valid=%b addr=%h want 1/80000000", req_valid, req_addr);
    end
    tick();
    n_checks++;
    if (req_addr !== 32'h8000_0000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_no_ready: got addr=%h out_valid=%b want 80000000/0", req_addr, out_valid);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_req, exp_out;
    int n_out;
    do_reset();
    lat = 1; req_ready = 1'b1; out_ready = 1'b1;
    exp_req = 32'h8000_0000; exp_out = 32'h8000_0000; n_out = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (req_fired) begin
        n_checks++;
        if (req_fired_addr !== exp_req) begin
          n_fail++; $display("FAIL stream_req_addr: got %h want %h", req_fired_addr, exp_req);
        end
        exp_req += 32'd4;
      end
      if (out_fired) begin
        n_checks++;
        if (out_fired_pc !== exp_out || out_fired_inst !== mem_word(exp_out)) begin
          n_fail++;
          $display("FAIL stream_out: got pc=%h inst=%h want pc=%h inst=%h",
                   out_fired_pc, out_fired_inst, exp_out, mem_word(exp_out));
        end
        exp_out += 32'd4;
        n_out++;
      end
    end
    n_checks++;
    if (n_out < 20) begin
      n_fail++; $display("FAIL stream_progress: got %0d outputs want >= 20", n_out);
    end
  endtask

  task automatic test_backpressure();
    int nreq;
    do_reset();
    lat = 1; req_ready = 1'b1; out_ready = 1'b0; nreq = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_fired) nreq++;
    end
    n_checks++;
    if (nreq != Depth) begin
      n_fail++; $display("FAIL bp_req_count: got %0d want %0d", nreq, Depth);
    end
    n_checks++;
    if (req_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_req_valid: got %b want 0", req_valid);
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000 || out_inst !== mem_word(32'h8000_0000)) begin
      n_fail++;
      $display("FAIL bp_head: got valid=%b pc=%h inst=%h want 1/80000000/%h",
               out_valid, out_pc, out_inst, mem_word(32'h8000_0000));
    end
  endtask

  task automatic test_redirect();
    logic got_req, got_out;
    do_reset();
    lat = 3; req_ready = 1'b1; out_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_setup_resp: got %b want 0", resp_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_1002;
    #1;
    n_checks++;
    if (req_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_req_valid: got %b want 0", req_valid);
    end
    tick();
    redirect_valid = 1'b0;
    got_req = 1'b0; got_out = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_fired && !got_req) begin
        got_req = 1'b1;
        n_checks++;
        if (req_fired_addr !== 32'h8000_1000) begin
          n_fail++; $display("FAIL redir_req_addr: got %h want 80001000", req_fired_addr);
        end
      end
      if (out_fired && !got_out) begin
        got_out = 1'b1;
        n_checks++;
        if (out_fired_pc !== 32'h8000_1000 || out_fired_inst !== mem_word(32'h8000_1000)) begin
          n_fail++;
          $display("FAIL redir_first_out: got pc=%h inst=%h want 80001000/%h",
                   out_fired_pc, out_fired_inst, mem_word(32'h8000_1000));
        end
      end
    end
    n_checks++;
    if (!got_out) begin
      n_fail++; $display("FAIL redir_timeout: got no output want one within 20 cycles");
    end
  endtask

  task automatic test_coincident();
    logic got_out;
    int stale;
    do_reset();
    lat = 1; req_ready = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (resp_valid !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL coin_setup: got resp_valid=%b out_valid=%b want 1/1", resp_valid, out_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_2000;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL coin_empty_after: got out_valid=%b want 0", out_valid);
    end
    got_out = 1'b0; stale = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_fired && out_fired_pc < 32'h8000_2000) stale++;
      if (out_fired && !got_out) begin
        got_out = 1'b1;
        n_checks++;
        if (out_fired_pc !== 32'h8000_2000) begin
          n_fail++; $display("FAIL coin_first_out: got pc=%h want 80002000", out_fired_pc);
        end
      end
    end
    n_checks++;
    if (stale != 0 || !got_out) begin
      n_fail++;
      $display("FAIL coin_stale: got stale=%0d seen=%b want 0/1", stale, got_out);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    lat = 1; req_ready = 1'b1; out_ready = 1'b1;
    tick();
    n_checks++;
    if (resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL byp_setup_resp: got %b want 1", resp_valid);
    end
`ifdef YSYX_25030093_FQ_BYPASS_EN
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000 || out_inst !== mem_word(32'h8000_0000)) begin
      n_fail++;
      $display("FAIL byp_same_cycle: got valid=%b pc=%h inst=%h want 1/80000000/%h",
               out_valid, out_pc, out_inst, mem_word(32'h8000_0000));
    end
`else
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL byp_not_same_cycle: got out_valid=%b want 0", out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000 || out_inst !== mem_word(32'h8000_0000)) begin
      n_fail++;
      $display("FAIL byp_next_cycle: got valid=%b pc=%h inst=%h want 1/80000000/%h",
               out_valid, out_pc, out_inst, mem_word(32'h8000_0000));
    end
`endif
  endtask

  task automatic test_wrap();
    logic [31:0] addrs [2];
    int nreq;
    logic got_out;
    do_reset();
    lat = 1; req_ready = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    nreq = 0; got_out = 1'b0;
    addrs[0] = '0; addrs[1] = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (req_fired && nreq < 2) begin
        addrs[nreq] = req_fired_addr;
        nreq++;
      end
      if (out_fired && !got_out) begin
        got_out = 1'b1;
        n_checks++;
        if (out_fired_pc !== 32'hFFFF_FFFC) begin
          n_fail++; $display("FAIL wrap_first_out: got pc=%h want fffffffc", out_fired_pc);
        end
      end
    end
    n_checks++;
    if (nreq != 2 || addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL wrap_addrs: got n=%0d %h %h want 2 fffffffc 00000000", nreq, addrs[0], addrs[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic got_out;
    do_reset();
    lat = 2; req_ready = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_state: got req=%b addr=%h out_valid=%b want 1/80000000/0",
               req_valid, req_addr, out_valid);
    end
    got_out = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_fired && !got_out) begin
        got_out = 1'b1;
        n_checks++;
        if (out_fired_pc !== 32'h8000_0000 || out_fired_inst !== mem_word(32'h8000_0000)) begin
          n_fail++;
          $display("FAIL mid_reset_first_out: got pc=%h inst=%h want 80000000/%h",
                   out_fired_pc, out_fired_inst, mem_word(32'h8000_0000));
        end
      end
    end
    n_checks++;
    if (!got_out) begin
      n_fail++; $display("FAIL mid_reset_timeout: got no output want one within 10 cycles");
    end
  endtask

  initial begin
    rst = 1'b0;
    req_ready = 1'b0;
    out_ready = 1'b0;
    resp_valid = 1'b0;
    resp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_coincident();
    test_bypass();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
